// File: rtl/spi_master.sv
// rtl/spi_master.sv - single-byte SPI initiator with START/BUSY/DONE handshake, all four CPOL/CPHA modes
module spi_master #(
   parameter int CLK_DIV = 2
) (
   input  logic       PCLK,
   input  logic       PRESET,
   input  logic       START,
   input  logic [1:0] MODE,
   input  logic [7:0] TX_DATA,
   input  logic       MISO,
   output logic       SCK,
   output logic       SS_N,
   output logic       MOSI,
   output logic [7:0] RX_DATA,
   output logic       BUSY,
   output logic       DONE
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LEAD,
      S_XFER,
      S_TRAIL
   } state_t;

   // Last value of the half-period counter; a "tick" ends one SCK half-period.
   localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

   state_t     state_q,   state_d;
   logic [7:0] div_q,     div_d;
   logic [4:0] edge_q,    edge_d;
   logic [1:0] mode_q,    mode_d;
   logic [7:0] tx_sh_q,   tx_sh_d;
   logic [7:0] rx_sh_q,   rx_sh_d;
   logic       sck_q,     sck_d;
   logic       ss_n_q,    ss_n_d;
   logic       mosi_q,    mosi_d;
   logic [7:0] rx_data_q, rx_data_d;
   logic       busy_q,    busy_d;
   logic       done_q,    done_d;

   logic       tick;
   logic [4:0] k;

   assign tick = (div_q == DIV_LAST);
   // Index of the SCK edge that the next tick produces (1..16).
   assign k    = edge_q + 5'd1;

   // Next-state and output logic; LEAD and XFER share the edge engine since
   // LEAD simply ends with the first SCK edge.
   always_comb begin
      state_d   = state_q;
      div_d     = div_q;
      edge_d    = edge_q;
      mode_d    = mode_q;
      tx_sh_d   = tx_sh_q;
      rx_sh_d   = rx_sh_q;
      sck_d     = sck_q;
      ss_n_d    = ss_n_q;
      mosi_d    = mosi_q;
      rx_data_d = rx_data_q;
      busy_d    = busy_q;
      done_d    = 1'b0;

      case (state_q)
         S_IDLE: begin
            // Idle SCK level follows CPOL so it is settled before SS_N falls.
            sck_d  = MODE[1];
            div_d  = 8'd0;
            edge_d = 5'd0;
            if (START) begin
               mode_d  = MODE;
               tx_sh_d = TX_DATA;
               rx_sh_d = 8'h00;
               ss_n_d  = 1'b0;
               busy_d  = 1'b1;
               mosi_d  = TX_DATA[7];
               state_d = S_LEAD;
            end
         end

         S_LEAD, S_XFER: begin
            if (!tick) begin
               div_d = div_q + 8'd1;
            end else begin
               div_d   = 8'd0;
               sck_d   = ~sck_q;
               edge_d  = k;
               state_d = (k == 5'd16) ? S_TRAIL : S_XFER;
               if (k[0]) begin
                  // Leading edge: CPHA=1 launches data, CPHA=0 captures.
                  if (mode_q[0]) begin
                     mosi_d  = tx_sh_q[7];
                     tx_sh_d = {tx_sh_q[6:0], 1'b0};
                  end else begin
                     rx_sh_d = {rx_sh_q[6:0], MISO};
                  end
               end else begin
                  // Trailing edge: CPHA=1 captures, CPHA=0 launches the next
                  // bit except after the final edge, where MOSI just holds.
                  if (mode_q[0]) begin
                     rx_sh_d = {rx_sh_q[6:0], MISO};
                  end else if (k != 5'd16) begin
                     mosi_d  = tx_sh_q[6];
                     tx_sh_d = {tx_sh_q[6:0], 1'b0};
                  end
               end
            end
         end

         S_TRAIL: begin
            sck_d = mode_q[1];
            if (!tick) begin
               div_d = div_q + 8'd1;
            end else begin
               div_d     = 8'd0;
               ss_n_d    = 1'b1;
               busy_d    = 1'b0;
               done_d    = 1'b1;
               rx_data_d = rx_sh_q;
               state_d   = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers; reset aborts any transfer on the spot.
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state_q   <= S_IDLE;
         div_q     <= 8'd0;
         edge_q    <= 5'd0;
         mode_q    <= 2'b00;
         tx_sh_q   <= 8'h00;
         rx_sh_q   <= 8'h00;
         sck_q     <= 1'b0;
         ss_n_q    <= 1'b1;
         mosi_q    <= 1'b0;
         rx_data_q <= 8'h00;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         div_q     <= div_d;
         edge_q    <= edge_d;
         mode_q    <= mode_d;
         tx_sh_q   <= tx_sh_d;
         rx_sh_q   <= rx_sh_d;
         sck_q     <= sck_d;
         ss_n_q    <= ss_n_d;
         mosi_q    <= mosi_d;
         rx_data_q <= rx_data_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign SCK     = sck_q;
   assign SS_N    = ss_n_q;
   assign MOSI    = mosi_q;
   assign RX_DATA = rx_data_q;
   assign BUSY    = busy_q;
   assign DONE    = done_q;

endmodule

// File: tb/tb_spi_master.sv
// tb/tb_spi_master.sv - self-checking bench for spi_master with RX scoreboard and SPI slave model
module tb_spi_master;

   logic       PCLK = 1'b0;
   logic       PRESET, START, MISO, SCK, SS_N, MOSI, BUSY, DONE;
   logic [1:0] MODE;
   logic [7:0] TX_DATA, RX_DATA;

   logic       START1, SCK1, SS_N1, MOSI1, BUSY1, DONE1;
   logic [1:0] MODE1;
   logic [7:0] TX1, RX1;

   logic       loop, sl_miso;

   always #5 PCLK = ~PCLK;

   assign MISO = loop ? MOSI : sl_miso;

   spi_master #(.CLK_DIV(2)) dut (
      .PCLK(PCLK), .PRESET(PRESET), .START(START), .MODE(MODE), .TX_DATA(TX_DATA),
      .MISO(MISO), .SCK(SCK), .SS_N(SS_N), .MOSI(MOSI), .RX_DATA(RX_DATA),
      .BUSY(BUSY), .DONE(DONE)
   );

   spi_master #(.CLK_DIV(1)) dut1 (
      .PCLK(PCLK), .PRESET(PRESET), .START(START1), .MODE(MODE1), .TX_DATA(TX1),
      .MISO(MOSI1), .SCK(SCK1), .SS_N(SS_N1), .MOSI(MOSI1), .RX_DATA(RX1),
      .BUSY(BUSY1), .DONE(DONE1)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   logic [7:0] exp_q[$];
   logic [7:0] exp1_q[$];

   int   cyc = 0, t0 = 0, lat = 0, ss_low = 0, sck_edges = 0, bad_mosi = 0, done_cnt = 0;
   logic prev_sck = 1'b0, prev_mosi = 1'b0, prev_ss = 1'b1, prev_busy = 1'b0;
   logic cpol = 1'b0, cpha = 1'b0;
   logic [7:0] sl_tx = 8'h00, sl_sh = 8'h00, sl_rx = 8'h00;

   int   t0_1 = 0, d1_n = 0, ss1_high = 0;
   int   d1_t[2];
   bit   b1_started = 1'b0;

   // Monitor, slave model and scoreboard, sampled 2 time units after each rising edge.
   always @(posedge PCLK) begin
      #2;
      cyc++;
      if (BUSY && !prev_busy) t0 = cyc;
      if (!SS_N) ss_low++;
      if (!SS_N && prev_ss) begin
         sl_sh = sl_tx;
         if (!cpha) begin
            sl_miso = sl_sh[7];
            sl_sh   = {sl_sh[6:0], 1'b0};
         end
      end
      if (!SS_N && SCK != prev_sck) begin
         sck_edges++;
         if (SCK != cpol) begin
            if (!cpha) sl_rx = {sl_rx[6:0], MOSI};
            else begin
               sl_miso = sl_sh[7];
               sl_sh   = {sl_sh[6:0], 1'b0};
            end
         end else begin
            if (cpha) sl_rx = {sl_rx[6:0], MOSI};
            else begin
               sl_miso = sl_sh[7];
               sl_sh   = {sl_sh[6:0], 1'b0};
            end
         end
      end
      if (!SS_N && !prev_ss && MOSI != prev_mosi) begin
         if (!(SCK != prev_sck && ((SCK != cpol) == cpha))) bad_mosi++;
      end
      if (DONE) begin
         done_cnt++;
         lat = cyc - t0;
         if (exp_q.size() == 0) check("rx_unexpected_done", DONE, 0);
         else check("rx_data", RX_DATA, exp_q.pop_front());
      end
      prev_sck  = SCK;
      prev_mosi = MOSI;
      prev_ss   = SS_N;
      prev_busy = BUSY;

      if (BUSY1 && !b1_started) begin
         b1_started = 1'b1;
         t0_1       = cyc;
      end
      if (DONE1) begin
         if (d1_n < 2) d1_t[d1_n] = cyc - t0_1;
         d1_n++;
         if (exp1_q.size() == 0) check("rx1_unexpected_done", DONE1, 0);
         else check("rx1_data", RX1, exp1_q.pop_front());
      end
      if (b1_started && d1_n < 2 && SS_N1) ss1_high++;
   end

   task automatic set_mode(input logic [1:0] m);
      MODE = m;
      cpol = m[1];
      cpha = m[0];
      repeat (3) @(negedge PCLK);
   endtask

   task automatic go(input logic [7:0] d, input logic [7:0] exp, input bit push);
      ss_low    = 0;
      sck_edges = 0;
      bad_mosi  = 0;
      done_cnt  = 0;
      sl_rx     = 8'h00;
      TX_DATA   = d;
      START     = 1'b1;
      if (push) exp_q.push_back(exp);
      @(negedge PCLK);
      START = 1'b0;
   endtask

   task automatic wait_done(input int target);
      int n = 0;
      while (done_cnt < target && n < 400) begin
         @(negedge PCLK);
         n++;
      end
      check("done_count", done_cnt, target);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not reach its end");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      PRESET = 1'b1; START = 1'b0; MODE = 2'b00; TX_DATA = 8'h00;
      loop = 1'b1; sl_miso = 1'b0;
      START1 = 1'b0; MODE1 = 2'b00; TX1 = 8'h00;
      repeat (3) @(negedge PCLK);
      check("reset_sck", SCK, 0);
      check("reset_ss_n", SS_N, 1);
      check("reset_mosi", MOSI, 0);
      check("reset_rx", RX_DATA, 8'h00);
      check("reset_busy", BUSY, 0);
      check("reset_done", DONE, 0);
      PRESET = 1'b0;

      // Mode 00 loopback, 0xA5
      set_mode(2'b00);
      loop = 1'b1;
      go(8'hA5, 8'hA5, 1);
      wait_done(1);
      check("m00_latency", lat, 34);
      check("m00_ss_low_cycles", ss_low, 34);
      check("m00_sck_edges", sck_edges, 16);
      check("m00_slave_rx", sl_rx, 8'hA5);
      check("m00_mosi_edge", bad_mosi, 0);
      @(negedge PCLK);
      check("m00_done_pulse", DONE, 0);
      check("m00_busy_after", BUSY, 0);
      check("m00_ss_n_after", SS_N, 1);

      // Mode 11 against a slave returning 0xC3
      set_mode(2'b11);
      check("m11_sck_idle_before", SCK, 1);
      loop  = 1'b0;
      sl_tx = 8'hC3;
      go(8'h3C, 8'hC3, 1);
      wait_done(1);
      check("m11_slave_rx", sl_rx, 8'h3C);
      check("m11_sck_edges", sck_edges, 16);
      @(negedge PCLK);
      check("m11_sck_idle_after", SCK, 1);

      // Modes 01 and 10 loopback, 0x81
      loop = 1'b1;
      set_mode(2'b01);
      go(8'h81, 8'h81, 1);
      wait_done(1);
      check("m01_mosi_edge", bad_mosi, 0);
      set_mode(2'b10);
      go(8'h81, 8'h81, 1);
      wait_done(1);
      check("m10_mosi_edge", bad_mosi, 0);
      check("m10_slave_rx", sl_rx, 8'h81);

      // START re-pulsed at t0+10 must be ignored
      set_mode(2'b00);
      go(8'h12, 8'h12, 1);
      repeat (9) @(negedge PCLK);
      START = 1'b1; TX_DATA = 8'hFF; MODE = 2'b11;
      @(negedge PCLK);
      START = 1'b0; MODE = 2'b00;
      wait_done(1);
      repeat (5) @(negedge PCLK);
      check("repulse_single_done", done_cnt, 1);
      check("repulse_slave_rx", sl_rx, 8'h12);

      // Reset at t0+20 aborts the transfer
      go(8'h66, 8'h00, 0);
      repeat (19) @(negedge PCLK);
      PRESET = 1'b1;
      @(negedge PCLK);
      check("abort_ss_n", SS_N, 1);
      check("abort_sck", SCK, 0);
      check("abort_busy", BUSY, 0);
      check("abort_rx", RX_DATA, 8'h00);
      check("abort_done", DONE, 0);
      PRESET = 1'b0;
      repeat (40) @(negedge PCLK);
      check("abort_no_done", done_cnt, 0);
      go(8'h55, 8'h55, 1);
      wait_done(1);

      // Back-to-back with START held high, CLK_DIV=1
      exp1_q.push_back(8'h01);
      exp1_q.push_back(8'h02);
      TX1 = 8'h01;
      START1 = 1'b1;
      n = 0;
      while (!b1_started && n < 20) begin @(negedge PCLK); n++; end
      check("b2b_started", b1_started, 1);
      TX1 = 8'h02;
      n = 0;
      while (d1_n < 1 && n < 100) begin @(negedge PCLK); n++; end
      @(negedge PCLK);
      START1 = 1'b0;
      n = 0;
      while (d1_n < 2 && n < 100) begin @(negedge PCLK); n++; end
      check("b2b_done_count", d1_n, 2);
      check("b2b_done0_time", d1_t[0], 17);
      check("b2b_done1_time", d1_t[1], 35);
      check("b2b_ss_high_cycles", ss1_high, 1);

      repeat (5) @(negedge PCLK);
      check("scoreboard_drained", exp_q.size(), 0);
      check("scoreboard1_drained", exp1_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
